// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Each grant issues a single write, waits for the FIFO response, then pulses done or retries.
module fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    fifo_wr_en,
    output logic [WIDTH-1:0]        fifo_data_in,
    input  logic                    fifo_full,
    input  logic                    fifo_wr_ack,
    input  logic                    fifo_overflow,
    output logic                    ovf_err,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     win_q, win_d;
    logic [IW-1:0]     last_q, last_d;
    logic              lock_q, lock_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW:0]       pick_idle, pick_ack;
    logic              go_write;

    // Returns {found, index}; the search begins just after 'after' and visits 'after' itself last.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] after);
        logic [IW:0] res;
        int j;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(after) + k) % NREQ;
            if (r[j]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        pick_idle = rr_pick(req, last_q);
        pick_ack  = rr_pick(req & ~gnt_q, win_q);
        state_d   = state_q;
        gnt_d     = gnt_q;
        win_d     = win_q;
        last_d    = last_q;
        lock_d    = lock_q;
        data_d    = data_q;
        ovf_d     = ovf_q | ((state_q == ACK) && fifo_overflow);
        go_write  = 1'b0;
        done      = '0;
        case (state_q)
            IDLE: begin
                // A winner whose write was refused keeps priority until it completes.
                if (lock_q) begin
                    if (!fifo_full) go_write = 1'b1;
                end else if (pick_idle[IW] && !fifo_full) begin
                    win_d    = pick_idle[IW-1:0];
                    go_write = 1'b1;
                end
            end
            WRITE: state_d = ACK;
            ACK: begin
                if (fifo_wr_ack) begin
                    done   = gnt_q;
                    last_d = win_q;
                    if (pick_ack[IW] && !fifo_full) begin
                        win_d    = pick_ack[IW-1:0];
                        go_write = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!fifo_full) begin
                    go_write = 1'b1;
                end else begin
                    state_d = IDLE;
                    lock_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (go_write) begin
            state_d     = WRITE;
            gnt_d       = '0;
            gnt_d[win_d] = 1'b1;
            lock_d      = 1'b0;
            data_d      = req_data[int'(win_d)*WIDTH +: WIDTH];
        end
        wr_en_d = go_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            win_q   <= '0;
            last_q  <= LAST_RST;
            lock_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            ovf_q   <= ovf_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
        end
    end

    assign gnt          = gnt_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign ovf_err      = ovf_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO model on its write side.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  gnt, done;
    logic        fifo_wr_en;
    logic [15:0] fifo_data_in;
    logic        fifo_full, fifo_wr_ack, fifo_overflow;
    logic        ovf_err, busy;

    // FIFO model
    logic        rd = 1'b0;
    logic        force_ovf = 1'b0;
    int          cnt;
    logic [15:0] q[$];

    int total = 0;
    int bad = 0;
    logic prev_wr = 1'b0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        wr;
        logic [15:0] data;
        logic [3:0]  done;
        logic        busy;
    } row_t;
    row_t tbl[17];

    logic [15:0] words[4];

    fifo_wr_arbiter #(.WIDTH(16), .NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign fifo_full = (cnt >= 8);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 0;
            fifo_wr_ack   <= 1'b0;
            fifo_overflow <= 1'b0;
            q.delete();
        end else begin
            fifo_wr_ack   <= fifo_wr_en && !fifo_full && !force_ovf;
            fifo_overflow <= fifo_wr_en && (fifo_full || force_ovf);
            if (fifo_wr_en && !fifo_full && !force_ovf) q.push_back(fifo_data_in);
            if (rd && cnt > 0) void'(q.pop_front());
            cnt <= cnt + ((fifo_wr_en && !fifo_full && !force_ovf) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic w,
                           input logic [15:0] d, input logic [3:0] dn, input logic b);
        chk({tag, ".gnt"},  32'(gnt), 32'(g));
        chk({tag, ".wr"},   32'(fifo_wr_en), 32'(w));
        chk({tag, ".data"}, 32'(fifo_data_in), 32'(d));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic step(input bit arst = 1'b0);
        @(posedge clk);
        if (arst) rst_n = 1'b0;
        #1;
        chk("no_b2b_wr", 32'(prev_wr && fifo_wr_en), 32'(0));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
        chk("done_in_gnt", 32'(done & ~gnt), 32'(0));
        prev_wr = fifo_wr_en;
    endtask

    task automatic set_words();
        req_data = {words[3], words[2], words[1], words[0]};
    endtask

    initial begin
        words[0] = 16'h1000; words[1] = 16'h1111; words[2] = 16'h2222; words[3] = 16'h3333;
        set_words();
        tbl[0]  = '{4'hF, 4'b0001, 1'b1, 16'h1000, 4'b0000, 1'b1};
        tbl[1]  = '{4'hF, 4'b0001, 1'b0, 16'h1000, 4'b0001, 1'b1};
        tbl[2]  = '{4'hF, 4'b0010, 1'b1, 16'h1111, 4'b0000, 1'b1};
        tbl[3]  = '{4'hF, 4'b0010, 1'b0, 16'h1111, 4'b0010, 1'b1};
        tbl[4]  = '{4'hF, 4'b0100, 1'b1, 16'h2222, 4'b0000, 1'b1};
        tbl[5]  = '{4'hF, 4'b0100, 1'b0, 16'h2222, 4'b0100, 1'b1};
        tbl[6]  = '{4'hF, 4'b1000, 1'b1, 16'h3333, 4'b0000, 1'b1};
        tbl[7]  = '{4'hF, 4'b1000, 1'b0, 16'h3333, 4'b1000, 1'b1};
        tbl[8]  = '{4'hF, 4'b0001, 1'b1, 16'h1000, 4'b0000, 1'b1};
        tbl[9]  = '{4'hF, 4'b0001, 1'b0, 16'h1000, 4'b0001, 1'b1};
        tbl[10] = '{4'hF, 4'b0010, 1'b1, 16'h1111, 4'b0000, 1'b1};
        tbl[11] = '{4'hF, 4'b0010, 1'b0, 16'h1111, 4'b0010, 1'b1};
        tbl[12] = '{4'hF, 4'b0100, 1'b1, 16'h2222, 4'b0000, 1'b1};
        tbl[13] = '{4'hF, 4'b0100, 1'b0, 16'h2222, 4'b0100, 1'b1};
        tbl[14] = '{4'hF, 4'b1000, 1'b1, 16'h3333, 4'b0000, 1'b1};
        tbl[15] = '{4'hF, 4'b1000, 1'b0, 16'h3333, 4'b1000, 1'b1};
        tbl[16] = '{4'hF, 4'b0000, 1'b0, 16'h3333, 4'b0000, 1'b0};

        // Reset held with all producers requesting
        req = 4'hF;
        repeat (3) step();
        chk_out("rst", 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
        chk("rst.ovf", 32'(ovf_err), 32'(0));
        rst_n = 1'b1;

        // Fairness: eight writes fill the FIFO, then it stalls full
        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req;
            step();
            chk_out($sformatf("rr%0d", i), tbl[i].gnt, tbl[i].wr, tbl[i].data, tbl[i].done, tbl[i].busy);
        end
        chk("rr.fifo_cnt", 32'(q.size()), 32'(8));
        for (int i = 0; i < 8 && i < q.size(); i++)
            chk($sformatf("rr.fifo%0d", i), 32'(q[i]), 32'(words[i % 4]));

        // Full stall until one read frees a slot
        req = 4'b0010;
        words[1] = 16'hBEEF; set_words();
        step(); chk_out("full0", 4'b0000, 1'b0, 16'h3333, 4'b0000, 1'b0);
        step(); chk_out("full1", 4'b0000, 1'b0, 16'h3333, 4'b0000, 1'b0);
        rd = 1'b1;
        step(); chk_out("full_rd", 4'b0000, 1'b0, 16'h3333, 4'b0000, 1'b0);
        rd = 1'b0;
        step(); chk_out("full_wr", 4'b0010, 1'b1, 16'hBEEF, 4'b0000, 1'b1);
        step(); chk_out("full_ack", 4'b0010, 1'b0, 16'hBEEF, 4'b0010, 1'b1);
        req = 4'b0000;
        step(); chk_out("full_idle", 4'b0000, 1'b0, 16'hBEEF, 4'b0000, 1'b0);
        chk("full.fifo_cnt", 32'(q.size()), 32'(8));
        if (q.size() > 0) chk("full.tail", 32'(q[q.size()-1]), 32'(16'hBEEF));
        rd = 1'b1;
        repeat (8) step();
        rd = 1'b0;

        // Single producer
        words[1] = 16'h1111; words[2] = 16'hA5A5; set_words();
        req = 4'b0100;
        step(); chk_out("one_wr", 4'b0100, 1'b1, 16'hA5A5, 4'b0000, 1'b1);
        step(); chk_out("one_ack", 4'b0100, 1'b0, 16'hA5A5, 4'b0100, 1'b1);
        req = 4'b0000;
        step(); chk_out("one_idle", 4'b0000, 1'b0, 16'hA5A5, 4'b0000, 1'b0);
        chk("one.fifo_cnt", 32'(q.size()), 32'(1));
        if (q.size() > 0) chk("one.fifo0", 32'(q[0]), 32'(16'hA5A5));
        rd = 1'b1;
        step();
        rd = 1'b0;

        // Overflow response: producer 3 retried before producer 0
        req = 4'b1001;
        force_ovf = 1'b1;
        step(); chk_out("ovf_wr", 4'b1000, 1'b1, 16'h3333, 4'b0000, 1'b1);
        step(); chk_out("ovf_resp", 4'b1000, 1'b0, 16'h3333, 4'b0000, 1'b1);
        chk("ovf_resp.ovf", 32'(ovf_err), 32'(0));
        force_ovf = 1'b0;
        step(); chk_out("ovf_retry", 4'b1000, 1'b1, 16'h3333, 4'b0000, 1'b1);
        chk("ovf_retry.ovf", 32'(ovf_err), 32'(1));
        step(); chk_out("ovf_ack", 4'b1000, 1'b0, 16'h3333, 4'b1000, 1'b1);
        req = 4'b0001;
        step(); chk_out("ovf_p0wr", 4'b0001, 1'b1, 16'h1000, 4'b0000, 1'b1);
        step(); chk_out("ovf_p0ack", 4'b0001, 1'b0, 16'h1000, 4'b0001, 1'b1);
        req = 4'b0000;
        step(); chk_out("ovf_idle", 4'b0000, 1'b0, 16'h1000, 4'b0000, 1'b0);
        chk("ovf_sticky", 32'(ovf_err), 32'(1));
        chk("ovf.fifo_cnt", 32'(q.size()), 32'(2));

        // Async reset landing on the ACK cycle
        req = 4'b0010;
        step(); chk_out("ra_wr", 4'b0010, 1'b1, 16'h1111, 4'b0000, 1'b1);
        step(1'b1); chk_out("ra_rst", 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
        chk("ra_rst.ovf", 32'(ovf_err), 32'(0));
        req = 4'b0011;
        step(); chk_out("ra_hold", 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step(); chk_out("ra_p0wr", 4'b0001, 1'b1, 16'h1000, 4'b0000, 1'b1);
        step(); chk_out("ra_p0ack", 4'b0001, 1'b0, 16'h1000, 4'b0001, 1'b1);
        req = 4'b0010;
        step(); chk_out("ra_p1wr", 4'b0010, 1'b1, 16'h1111, 4'b0000, 1'b1);
        step(); chk_out("ra_p1ack", 4'b0010, 1'b0, 16'h1111, 4'b0010, 1'b1);
        req = 4'b0000;
        step(); chk_out("ra_idle", 4'b0000, 1'b0, 16'h1111, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 16-bit synchronous FIFO among NREQ producers. Each producer raises a request with its data word; the arbiter grants one producer at a time, drives the FIFO `wr_en`/`data_in`, checks the FIFO `wr_ack`/`overflow` response, and returns a one-cycle completion pulse to the winner. It sits between the producer blocks and the FIFO write side, on the same clock and reset as the FIFO.

## Interface
- WIDTH, 16, FIFO data width
- NREQ, 4, number of producers (2..8)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset, shared with the FIFO
- req  input  NREQ  per-producer request, held until its `done`
- req_data  input  NREQ*WIDTH  producer i word in bits [i*WIDTH +: WIDTH], stable while req[i]=1
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle pulse, write of producer i accepted
- fifo_wr_en  output  1  to FIFO wr_en, registered
- fifo_data_in  output  WIDTH  to FIFO data_in, registered
- fifo_full  input  1  from FIFO full
- fifo_wr_ack  input  1  from FIFO wr_ack (registered in FIFO, valid cycle after wr_en)
- fifo_overflow  input  1  from FIFO overflow (same timing as wr_ack)
- ovf_err  output  1  sticky: an overflow response was seen
- busy  output  1  state != IDLE

## Operation
- States: IDLE, WRITE, ACK.
- IDLE: if any req and !fifo_full -> WRITE with winner granted; else stay.
- WRITE (exactly 1 cycle): gnt=winner, fifo_wr_en=1, fifo_data_in=captured winner word. Always -> ACK.
- ACK: gnt held, fifo_wr_en=0.
  - fifo_wr_ack=1: done[winner]=1; last pointer := winner; re-arbitrate with winner masked out; if another req and !fifo_full -> WRITE (new winner), else -> IDLE, gnt cleared.
  - fifo_overflow=1 (or neither ack nor overflow): no done; ovf_err set if overflow; retry same winner: -> WRITE if !fifo_full, else -> IDLE keeping winner locked (IDLE re-grants locked winner first, no arbitration).
- Arbitration: round-robin, search starts at last+1 mod NREQ; last resets to NREQ-1 so producer 0 wins first.
- fifo_data_in captured from req_data at the transition into WRITE; later changes to req_data ignored.
- Producer may drop req the cycle after done; must not drop req before done (undefined).
- ovf_err cleared only by reset.

## Timing
- Reset (async assert, sync release): state IDLE, gnt=0, done=0, fifo_wr_en=0, fifo_data_in=0, ovf_err=0, busy=0, last=NREQ-1, lock cleared. Reset mid-write abandons the transfer; no done issued.
- Latency: req seen in IDLE at cycle t -> fifo_wr_en at t+1 -> done at t+2.
- Back-to-back: sustained one write per 2 cycles (WRITE, ACK, WRITE, ...).
- fifo_full sampled combinationally in IDLE/ACK decision cycle; it reflects the FIFO count after the preceding write, so no write issues into a full FIFO under normal FIFO behaviour.
- fifo_wr_en is never high in two consecutive cycles.
- gnt one-hot or zero at all times; done only asserted where gnt is set.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 -> all outputs 0; release -> gnt=4'b0001 one cycle later, fifo_data_in=req_data[0].
- Single producer: req[2]=1, data 16'hA5A5 -> fifo_wr_en 1 cycle, data 16'hA5A5, done[2] 2 cycles after req; FIFO holds one entry 16'hA5A5.
- Fairness: all four req held, re-raised after done -> grant order 0,1,2,3,0,1,... with writes every 2 cycles; 8 writes fill the DEPTH=8 FIFO.
- Full stall: FIFO pre-filled to 8, req[1]=1 -> no fifo_wr_en, busy=0; one FIFO read -> write issues next cycle, done[1] follows.
- Forced overflow: bench returns fifo_overflow=1 instead of wr_ack on producer 3 -> no done[3], ovf_err=1, WRITE retried for producer 3 before any other producer.
- Async reset in ACK cycle -> gnt, done, fifo_wr_en 0 immediately; no done pulse; after release arbitration restarts at producer 0.
